pixel_pack_fsm: RTL and testbench

PIXEL_PACK_FSM -- requirements
Module: pixel_pack_fsm

---
 rtl/pixel_pack_pkg.sv | 30 +++
 rtl/pixel_pack_fsm_window.sv | 22 ++
 rtl/pixel_pack_fsm.sv | 140 ++++++++++++++
 tb/tb_pixel_pack_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared types and constants for the RGB pixel packer and its window detector.
package pixel_pack_pkg;

    typedef enum logic [1:0] {
        ST_PACK = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2
    } pack_state_e;

    localparam int unsigned SLOT_COUNT     = 5;
    localparam int unsigned BITS_PER_PIXEL = 3;
    localparam int unsigned LINE_END_BIT   = 15;
    localparam int unsigned WORD_W         = 16;
    localparam int unsigned ASM_W          = SLOT_COUNT * BITS_PER_PIXEL;
    localparam int unsigned SLOT_W         = 3;
    localparam int unsigned POS_W          = 11;
    localparam int unsigned DROP_W         = 8;

    localparam int unsigned DEF_XPOS_START = 192;
    localparam int unsigned DEF_XPOS_END   = 448;
    localparam int unsigned DEF_YPOS_START = 48;
    localparam int unsigned DEF_YPOS_END   = 432;

    // Position one {r,g,b} pixel at its slot inside the assembly word.
    function automatic logic [ASM_W-1:0] place_pixel(input logic [SLOT_W-1:0]         slot,
                                                     input logic [BITS_PER_PIXEL-1:0] rgb);
        return ASM_W'(rgb) << (BITS_PER_PIXEL * int'(slot));
    endfunction

endpackage

// File: rtl/pixel_pack_fsm_window.sv
// Raster window comparison, shared by the packing and unpacking sides.
module pixel_window_detect
    import pixel_pack_pkg::*;
#(
    parameter int unsigned XPOS_START = DEF_XPOS_START,
    parameter int unsigned XPOS_END   = DEF_XPOS_END,
    parameter int unsigned YPOS_START = DEF_YPOS_START,
    parameter int unsigned YPOS_END   = DEF_YPOS_END
) (
    input  logic [POS_W-1:0] hcount,
    input  logic [POS_W-1:0] vcount,
    output logic             in_win,
    output logic             line_end
);

    logic row_active;

    assign row_active = (vcount >= POS_W'(YPOS_START)) && (vcount < POS_W'(YPOS_END));
    assign in_win     = row_active && (hcount >= POS_W'(XPOS_START)) && (hcount < POS_W'(XPOS_END));
    assign line_end   = row_active && (hcount == POS_W'(XPOS_END));

endmodule

// File: rtl/pixel_pack_fsm.sv
// Packs five 3-bit RGB pixels per 16-bit FIFO word, holding the word while the FIFO is full.
// Optional partial-word flush at end of each active line: define PIXEL_PACK_LINE_FLUSH_EN.
module pixel_pack_fsm
    import pixel_pack_pkg::*;
#(
    parameter int unsigned XPOS_START = DEF_XPOS_START,
    parameter int unsigned XPOS_END   = DEF_XPOS_END,
    parameter int unsigned YPOS_START = DEF_YPOS_START,
    parameter int unsigned YPOS_END   = DEF_YPOS_END
) (
    input  logic        clk_20MHz,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        red_pix,
    input  logic        green_pix,
    input  logic        blue_pix,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        fifo_full,
    output logic [15:0] pixel_word,
    output logic        write_fifo,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    pack_state_e       state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_cur;
    logic [ASM_W-1:0]  asm_q, asm_d, asm_cur, asm_next;
    logic [WORD_W-1:0] pixel_word_q, pixel_word_d, word_out;
    logic              write_fifo_q, write_fifo_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              in_win, line_end, frame_start, flush_req, word_done;

    pixel_window_detect #(
        .XPOS_START (XPOS_START),
        .XPOS_END   (XPOS_END),
        .YPOS_START (YPOS_START),
        .YPOS_END   (YPOS_END)
    ) u_window (
        .hcount   (hcount),
        .vcount   (vcount),
        .in_win   (in_win),
        .line_end (line_end)
    );

    assign frame_start = (vcount == '0) && (hcount == '0);
    assign slot_cur    = frame_start ? '0 : slot_q;
    assign asm_cur     = frame_start ? '0 : asm_q;

`ifdef PIXEL_PACK_LINE_FLUSH_EN
    assign flush_req = line_end && (slot_cur != '0);
`else
    logic line_end_unused;
    assign flush_req       = 1'b0;
    assign line_end_unused = line_end;
`endif

    // Next-state logic; slot is always 0 while holding, so a flush never arises in HOLD.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_cur;
        asm_d        = asm_cur;
        pixel_word_d = pixel_word_q;
        write_fifo_d = 1'b0;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        word_done    = 1'b0;
        word_out     = '0;
        asm_next     = asm_cur;

        if (state_q == ST_HOLD) begin
            if (pix_en && in_win) begin
                overflow_d = 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + DROP_W'(1);
                end
            end
            if (!fifo_full) begin
                state_d      = ST_EMIT;
                write_fifo_d = 1'b1;
            end
        end else begin
            state_d = ST_PACK;
            if (flush_req) begin
                word_done              = 1'b1;
                word_out               = WORD_W'(asm_cur);
                word_out[LINE_END_BIT] = 1'b1;
                slot_d                 = '0;
                asm_d                  = '0;
            end else if (pix_en && in_win) begin
                asm_next = asm_cur | place_pixel(slot_cur, {red_pix, green_pix, blue_pix});
                if (slot_cur == SLOT_W'(SLOT_COUNT - 1)) begin
                    word_done = 1'b1;
                    word_out  = WORD_W'(asm_next);
                    slot_d    = '0;
                    asm_d     = '0;
                end else begin
                    slot_d = slot_cur + SLOT_W'(1);
                    asm_d  = asm_next;
                end
            end
            if (word_done) begin
                pixel_word_d = word_out;
                if (fifo_full) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d      = ST_EMIT;
                    write_fifo_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_20MHz) begin
        if (reset) begin
            state_q      <= ST_PACK;
            slot_q       <= '0;
            asm_q        <= '0;
            pixel_word_q <= '0;
            write_fifo_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            asm_q        <= asm_d;
            pixel_word_q <= pixel_word_d;
            write_fifo_q <= write_fifo_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pixel_word = pixel_word_q;
    assign write_fifo = write_fifo_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pixel_pack_fsm.sv
// Directed and randomized bench for pixel_pack_fsm against a queue-based packing model.
module tb_pixel_pack_fsm;

    localparam int XS = 192;
    localparam int XE = 448;
    localparam int YS = 48;
    localparam int YE = 432;

    logic        clk_20MHz = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        red_pix, green_pix, blue_pix;
    logic [10:0] hcount, vcount;
    logic        fifo_full;
    logic [15:0] pixel_word;
    logic        write_fifo;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_pass   = 0;
    int n_total  = 0;
    int n_strobe = 0;
    logic [15:0] last_word = '0;
    int row_strobes;

    // Reference model: pending pixels of the word being built, plus the word on the output.
    int          q[$];
    logic        m_hold  = 1'b0;
    logic        m_write = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_word  = '0;
    int          m_cnt   = 0;

    pixel_pack_fsm dut (
        .clk_20MHz  (clk_20MHz),
        .reset      (reset),
        .pix_en     (pix_en),
        .red_pix    (red_pix),
        .green_pix  (green_pix),
        .blue_pix   (blue_pix),
        .hcount     (hcount),
        .vcount     (vcount),
        .fifo_full  (fifo_full),
        .pixel_word (pixel_word),
        .write_fifo (write_fifo),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #25 clk_20MHz = ~clk_20MHz;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack_q();
        logic [15:0] w = '0;
        for (int k = 0; k < q.size(); k++) w |= 16'(q[k]) << (3 * k);
        return w;
    endfunction

    task automatic deliver(input logic [15:0] w, input logic full);
        m_word = w;
        if (full) m_hold = 1'b1;
        else      m_write = 1'b1;
    endtask

    task automatic model(input logic pen, input logic [2:0] rgb, input int h, input int v,
                         input logic full, input logic rst);
        bit row_on, inwin, lend;
        row_on = (v >= YS) && (v < YE);
        inwin  = row_on && (h >= XS) && (h < XE);
        lend   = row_on && (h == XE);
        if (rst) begin
            q.delete();
            m_hold = 0; m_write = 0; m_ovf = 0; m_word = '0; m_cnt = 0;
        end else begin
            m_write = 1'b0;
            if (v == 0 && h == 0) q.delete();
            if (m_hold) begin
                if (pen && inwin) begin
                    m_ovf = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                if (!full) begin
                    m_hold  = 1'b0;
                    m_write = 1'b1;
                end
            end else begin
                if (pen && inwin) begin
                    q.push_back(int'(rgb));
                    if (q.size() == 5) begin
                        deliver(pack_q(), full);
                        q.delete();
                    end
                end
`ifdef PIXEL_PACK_LINE_FLUSH_EN
                if (lend && q.size() != 0) begin
                    deliver(pack_q() | 16'h8000, full);
                    q.delete();
                end
`endif
            end
        end
    endtask

    task automatic cyc(input logic pen, input logic [2:0] rgb, input int h, input int v,
                       input logic full, input logic rst);
        reset     = rst;
        pix_en    = pen;
        {red_pix, green_pix, blue_pix} = rgb;
        hcount    = 11'(h);
        vcount    = 11'(v);
        fifo_full = full;
        model(pen, rgb, h, v, full, rst);
        @(posedge clk_20MHz);
        #1;
        check("write_fifo", 16'(write_fifo), 16'(m_write));
        check("pixel_word", pixel_word, m_word);
        check("overflow", 16'(overflow), 16'(m_ovf));
        check("drop_count", 16'(drop_count), 16'(m_cnt));
        if (write_fifo) begin
            n_strobe++;
            last_word = pixel_word;
        end
    endtask

    task automatic row(input int v, input int pen_pct, input int full_pct);
        for (int h = XS - 4; h <= XE + 4; h++)
            cyc(1'($urandom_range(99) < pen_pct), 3'($urandom), h, v,
                1'($urandom_range(99) < full_pct), 1'b0);
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 3'd0, 0, 0, 1'b0, 1'b1);
        cyc(1'b1, 3'd7, XS, YS, 1'b0, 1'b1);
        check("rst_word", pixel_word, 16'h0000);

        // Five known pixels into an empty FIFO
        for (int k = 0; k < 5; k++) cyc(1'b1, 3'(k + 1), XS + k, YS, 1'b0, 1'b0);
        check("first_strobe", 16'(write_fifo), 16'h0001);
        check("first_word", pixel_word, 16'h58D1);
        cyc(1'b0, 3'd0, XS + 5, YS, 1'b0, 1'b0);
        check("strobe_one_cycle", 16'(write_fifo), 16'h0000);

        // Random traffic with back-pressure
        row(YS + 1, 80, 15);
        row(YS + 2, 90, 30);

        // Frame start discards a partial word
        for (int k = 0; k < 3; k++) cyc(1'b1, 3'd7, XS + k, YS + 3, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 3'(k + 3), XS + k, YS, 1'b0, 1'b0);

        // Four cycles of FIFO full at word completion, pixels continuous
        cyc(1'b0, 3'd0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b1, 3'(k), XS + k, YS, 1'b0, 1'b0);
        cyc(1'b1, 3'd5, XS + 4, YS, 1'b1, 1'b0);
        for (int k = 5; k < 8; k++) cyc(1'b1, 3'd1, XS + k, YS, 1'b1, 1'b0);
        check("hold_no_strobe", 16'(write_fifo), 16'h0000);
        cyc(1'b1, 3'd1, XS + 8, YS, 1'b0, 1'b0);
        check("release_strobe", 16'(write_fifo), 16'h0001);
        check("drop4", 16'(drop_count), 16'd4);
        check("ovf_set", 16'(overflow), 16'h0001);

        // Drop counter saturation
        for (int k = 0; k < 4; k++) cyc(1'b1, 3'd2, XS + k, YS + 5, 1'b0, 1'b0);
        cyc(1'b1, 3'd3, XS + 4, YS + 5, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) cyc(1'b1, 3'($urandom), XS + 10, YS + 5, 1'b1, 1'b0);
        check("drop_sat", 16'(drop_count), 16'd255);
        for (int k = 0; k < 6; k++) cyc(1'b0, 3'd0, XS + 11 + k, YS + 5, 1'b0, 1'b0);
        check("ovf_sticky", 16'(overflow), 16'h0001);

        // Reset while holding a word
        for (int k = 0; k < 5; k++) cyc(1'b1, 3'd6, XS + k, YS + 6, 1'b1, 1'b0);
        cyc(1'b1, 3'd1, XS + 5, YS + 6, 1'b0, 1'b1);
        check("rst_hold_wr", 16'(write_fifo), 16'h0000);
        check("rst_hold_word", pixel_word, 16'h0000);
        check("rst_hold_cnt", 16'(drop_count), 16'h0000);
        for (int k = 0; k < 5; k++) cyc(1'b1, 3'(7 - k), XS + k, YS + 6, 1'b0, 1'b0);
        check("post_rst_word", pixel_word, 16'h3977);

        // Full continuous row, then the start of the next row
        cyc(1'b0, 3'd0, 0, 0, 1'b0, 1'b1);
        n_strobe = 0;
        for (int h = XS - 2; h <= XE + 3; h++)
            cyc(1'((h >= XS) && (h < XE)), 3'($urandom), h, YS + 10, 1'b0, 1'b0);
`ifdef PIXEL_PACK_LINE_FLUSH_EN
        row_strobes = 52;
        check("flush_flag", 16'(last_word[15]), 16'h0001);
        check("flush_unused_slots", 16'(last_word[14:3]), 16'h0000);
`else
        row_strobes = 51;
        check("row_no_flag", 16'(last_word[15]), 16'h0000);
`endif
        check("row_strobes", 16'(n_strobe), 16'(row_strobes));
        for (int h = XS - 2; h <= XS + 6; h++)
            cyc(1'(h >= XS), 3'($urandom), h, YS + 11, 1'b0, 1'b0);
        check("row2_strobes", 16'(n_strobe), 16'(row_strobes + 1));
        check("row2_flag", 16'(last_word[15]), 16'h0000);

        // Random traffic across line ends with heavy back-pressure
        row(YS + 12, 85, 40);
        row(YS + 13, 95, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
